mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12: word-address bits decoded; storage is 2**ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2: read latency in cycles from accept to response; legal range 1..8.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_waitrequest  output  1  request stall; a request is not accepted while high.
REQ-006 mem_id  input  2  requester tag; 1 = data cache, 2 = instruction cache, 0 and 3 legal.
REQ-007 mem_address  input  30  word address; only bits ADDR_W-1:0 are decoded, upper bits ignored (aliasing).
REQ-008 mem_read  input  1  read strobe.
REQ-009 mem_write  input  1  write strobe.
REQ-010 mem_writedata  input  32  write data.
REQ-011 mem_writedatamask  input  4  byte enables; bit i enables bits 8i+7:8i.
REQ-012 mem_readdata  output  32  read response data.
REQ-013 mem_readdataid  output  2  response tag; 0 = no response this cycle.

Function
REQ-014 Accept = (mem_read | mem_write) & ~mem_waitrequest, sampled at the rising edge; at most one request per cycle.
REQ-015 Requester holds address, strobes, id and data stable while waitrequest is high; the block ignores all inputs in non-accept cycles.
REQ-016 Accepted write: enabled bytes of the addressed word update at that edge; disabled bytes unchanged; mask 0000 is a legal no-op; no response produced.
REQ-017 Both strobes high on accept: the write is performed, the read is dropped, no response produced.
REQ-018 Accepted read at edge N: mem_readdataid = mem_id and mem_readdata = word contents valid for exactly the cycle following edge N+LATENCY-1 (LATENCY=1 -> visible right after edge N).
REQ-019 Read data reflects all writes accepted at earlier edges; a write accepted one cycle after a read does not alter that read's data.
REQ-020 Response pipeline: LATENCY stages of {valid, id, data}, advancing every cycle, never stalled; back-to-back reads yield back-to-back responses in issue order.
REQ-021 Read with mem_id = 0 is accepted and occupies a pipeline slot; its response is invisible (mem_readdataid = 0).
REQ-022 mem_readdata = 0 in every cycle where mem_readdataid = 0.
REQ-023 Without stall injection, mem_waitrequest = rst; reads and writes may interleave freely at full rate.

Reset
REQ-024 rst high: all pipeline stages invalidated, mem_readdataid = 0, mem_readdata = 0, mem_waitrequest = 1, stall LFSR loaded with 16'hACE1.
REQ-025 Reads in flight when rst rises are discarded; no response appears after rst falls.
REQ-026 Storage contents are not cleared by reset; contents are undefined before first write.
REQ-027 First accept possible at the first edge with rst low.

Configuration
REQ-028 Macro MEM_RESPONDER_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle when rst low; mem_waitrequest = rst | (lfsr[0] & lfsr[1]), approx. 25% stall rate.
REQ-029 LFSR stalls affect request acceptance only; the response pipeline continues to drain during stall cycles.
REQ-030 Macro undefined: no LFSR logic instantiated; mem_waitrequest = rst.

Verification
REQ-031 Write addr 0x010 data 0xDEADBEEF mask 1111, then read id 1 -> after LATENCY cycles readdataid = 1, readdata = 0xDEADBEEF, then readdataid returns to 0, readdata 0.
REQ-032 Word 0x020 = 0x11223344, write 0xAABBCCDD mask 0101, read id 2 -> readdata = 0x11BB33DD, readdataid = 2.
REQ-033 Reads of 0x001,0x002,0x003 on consecutive cycles with ids 1,2,1 -> three consecutive response cycles, same order, correct data and ids.
REQ-034 Read 0x010 id 1 accepted, rst asserted next cycle for 2 cycles -> no nonzero readdataid observed before or after rst falls; waitrequest high during rst.
REQ-035 Read and write both high to 0x030 (write 0x5A5A5A5A) -> no response; later read returns 0x5A5A5A5A; read with ADDR_W=12 at 0x1010 returns word 0x010 (aliasing).
REQ-036 With MEM_RESPONDER_STALL_EN, 1000 random requests held until accepted -> every read returns scoreboard-expected data in order, no request accepted while waitrequest high, waitrequest high in roughly 20-30% of cycles.

Source files
------------

// File: rtl/mem_responder_if.sv
// Requester/responder bus for mem_responder: request side plus tagged read-response side.
interface mem_responder_if;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  // A request is taken at a rising edge where (mem_read | mem_write) is high and
  // mem_waitrequest is low; the requester holds every request field stable until then.
  // Responses are unstalled: a nonzero mem_readdataid marks the single cycle its data is valid.
  modport master (
    input  mem_waitrequest, mem_readdata, mem_readdataid,
    output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );

  modport slave (
    output mem_waitrequest, mem_readdata, mem_readdataid,
    input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory model with byte-masked writes and a fixed-latency tagged read pipeline.
// Optional pseudo-random request stalls are enabled by defining MEM_RESPONDER_STALL_EN.
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input logic            clock,
  input logic            rst,
  mem_responder_if.slave bus
);

  logic              accept;
  logic              do_write;
  logic              do_read;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       mem [2**ADDR_W];

  logic              pipe_valid [LATENCY];
  logic [1:0]        pipe_id    [LATENCY];
  logic [31:0]       pipe_data  [LATENCY];

  // Upper address bits alias onto the decoded range.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_address[29:ADDR_W];

  assign word_addr = bus.mem_address[ADDR_W-1:0];
  assign accept    = (bus.mem_read | bus.mem_write) & ~bus.mem_waitrequest;
  assign do_write  = accept & bus.mem_write;
  // A combined read+write performs only the write.
  assign do_read   = accept & bus.mem_read & ~bus.mem_write;

  // Storage keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_writedatamask[i]) begin
          mem[word_addr][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
        end
      end
    end
  end

  // Stage 0 samples the word at the accept edge, so only writes from earlier edges are visible.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_id[i]    <= 2'd0;
        pipe_data[i]  <= 32'd0;
      end
    end else begin
      pipe_valid[0] <= do_read;
      pipe_id[0]    <= bus.mem_id;
      pipe_data[0]  <= mem[word_addr];
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  logic resp_visible;
  assign resp_visible       = pipe_valid[LATENCY-1] && (pipe_id[LATENCY-1] != 2'd0);
  assign bus.mem_readdataid = resp_visible ? pipe_id[LATENCY-1]   : 2'd0;
  assign bus.mem_readdata   = resp_visible ? pipe_data[LATENCY-1] : 32'd0;

`ifdef MEM_RESPONDER_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; two adjacent ones give roughly a 25% stall rate.
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign bus.mem_waitrequest = rst | (lfsr[0] & lfsr[1]);
`else
  assign bus.mem_waitrequest = rst;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios then randomized traffic vs a word-level model.
module tb_mem_responder;
  localparam int ADDR_W = 12;
  localparam int LAT    = 2;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  mem_responder_if bus();

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model [int];
  int          tests = 0;
  int          failed = 0;
  int          stall_cycles = 0;
  int          run_cycles = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic next_cycle();
    rsp_t        e;
    logic [1:0]  eid;
    logic [31:0] ed;
    @(negedge clock);
    eid = 2'd0;
    ed  = 32'd0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e   = exp_q.pop_front();
      eid = e.id;
      ed  = (e.id != 2'd0) ? e.data : 32'd0;
    end
    chk("readdataid", 32'(bus.mem_readdataid), 32'(eid));
    chk("readdata", bus.mem_readdata, ed);
`ifndef MEM_RESPONDER_STALL_EN
    chk("waitrequest", 32'(bus.mem_waitrequest), 32'(rst));
`else
    if (rst) begin
      chk("waitrequest_in_reset", 32'(bus.mem_waitrequest), 32'd1);
    end else begin
      run_cycles++;
      if (bus.mem_waitrequest) stall_cycles++;
    end
`endif
  endtask

  task automatic idle_inputs();
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.mem_id            = 2'd0;
    bus.mem_address       = 30'd0;
    bus.mem_writedata     = 32'd0;
    bus.mem_writedatamask = 4'd0;
  endtask

  // Present one request, hold it until accepted, and update the model at the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] id,
                       input logic [29:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    int          key;
    logic [31:0] nw;
    bus.mem_read          = rd;
    bus.mem_write         = wr;
    bus.mem_id            = id;
    bus.mem_address       = addr;
    bus.mem_writedata     = wdata;
    bus.mem_writedatamask = mask;
    for (int k = 0; k < 200 && bus.mem_waitrequest; k++) next_cycle();
    if (bus.mem_waitrequest) begin
      chk("accept_timeout", 32'(bus.mem_waitrequest), 32'd0);
    end else begin
      key = int'(addr[ADDR_W-1:0]);
      if (wr) begin
        nw = model.exists(key) ? model[key] : 32'd0;
        for (int i = 0; i < 4; i++) if (mask[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        model[key] = nw;
      end else if (rd) begin
        exp_q.push_back('{due: cyc + LAT, id: id, data: model[key]});
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    repeat (n) next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [29:0] a;
    int          op;
    idle_inputs();
    repeat (3) next_cycle();
    rst = 1'b0;

    // Full write then read back.
    issue(1'b0, 1'b1, 2'd1, 30'h010, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 1'b0, 2'd1, 30'h010, 32'd0, 4'h0);
    repeat (LAT + 2) next_cycle();

    // Partial byte mask merge.
    issue(1'b0, 1'b1, 2'd1, 30'h020, 32'h11223344, 4'hF);
    issue(1'b0, 1'b1, 2'd1, 30'h020, 32'hAABBCCDD, 4'b0101);
    issue(1'b1, 1'b0, 2'd2, 30'h020, 32'd0, 4'h0);
    repeat (LAT + 2) next_cycle();

    // Back-to-back reads produce back-to-back responses in order.
    issue(1'b0, 1'b1, 2'd1, 30'h001, 32'h0000_0101, 4'hF);
    issue(1'b0, 1'b1, 2'd1, 30'h002, 32'h0000_0202, 4'hF);
    issue(1'b0, 1'b1, 2'd1, 30'h003, 32'h0000_0303, 4'hF);
    issue(1'b1, 1'b0, 2'd1, 30'h001, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 2'd2, 30'h002, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 2'd1, 30'h003, 32'd0, 4'h0);
    repeat (LAT + 2) next_cycle();

    // Read in flight when reset hits must never surface.
    issue(1'b1, 1'b0, 2'd1, 30'h010, 32'd0, 4'h0);
    apply_reset(2);
    repeat (LAT + 3) next_cycle();

    // Combined strobes, aliasing, invisible id 0, no-op mask, write right after read.
    issue(1'b1, 1'b1, 2'd1, 30'h030, 32'h5A5A5A5A, 4'hF);
    repeat (LAT + 1) next_cycle();
    issue(1'b1, 1'b0, 2'd1, 30'h030, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 2'd2, 30'h1010, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 2'd0, 30'h010, 32'd0, 4'h0);
    issue(1'b0, 1'b1, 2'd1, 30'h010, 32'h12345678, 4'h0);
    issue(1'b1, 1'b0, 2'd3, 30'h010, 32'd0, 4'h0);
    issue(1'b0, 1'b1, 2'd1, 30'h010, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 1'b0, 2'd1, 30'h010, 32'd0, 4'h0);
    repeat (LAT + 2) next_cycle();

    // Randomized traffic over an initialized window, with random alias bits.
    for (int i = 0; i < 64; i++) issue(1'b0, 1'b1, 2'd1, 30'(256 + i), $urandom, 4'hF);
    for (int n = 0; n < 1000; n++) begin
      a  = (30'($urandom) & ~30'(2**ADDR_W - 1)) | 30'(256 + $urandom_range(0, 63));
      op = $urandom_range(0, 9);
      if (op < 5)      issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), a, 32'd0, 4'h0);
      else if (op < 9) issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, 4'($urandom_range(0, 15)));
      else             issue(1'b1, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) next_cycle();
    end
    repeat (LAT + 3) next_cycle();
    chk("responses_outstanding", 32'(exp_q.size()), 32'd0);
`ifdef MEM_RESPONDER_STALL_EN
    chk("stall_rate_in_range",
        32'((stall_cycles * 100 >= run_cycles * 15) && (stall_cycles * 100 <= run_cycles * 35)), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
